// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_seq and fetch_perf_cnt.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;
    localparam int PERF_W  = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: instructions consumed by decode and memory stall cycles.
// Both counters are free-running and wrap at 2^PERF_W.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              stall_en,
    output logic [PERF_W-1:0] fetch_cnt,
    output logic [PERF_W-1:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_en) begin
                fetch_cnt <= fetch_cnt + PERF_W'(1);
            end
            if (stall_en) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time and holds it for decode.
// Define FETCH_SEQ_PERF_EN to build the fetch/stall performance counters.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,

    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              dec_ready,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    // Handshakes: a memory transfer completes on a cycle with imem_req && imem_ready;
    // a decode transfer completes on a cycle with inst_valid && dec_ready. A redirect
    // in the same cycle cancels either transfer, so neither side may assume completion.

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              fetch_take;
    logic              dec_take;
    logic              stall_cycle;
    logic              unused_redirect_lsb;

    assign pc_inc              = pc + ADDR_W'(PC_STEP);
    assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign fetch_take  = (state == REQ)  && imem_ready && !redirect_valid;
    assign dec_take    = (state == HOLD) && dec_ready  && !redirect_valid;
    assign stall_cycle = (state == REQ)  && !imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem_ready) state_nxt = HOLD;
            HOLD:    if (dec_ready)  state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        // A redirect overrides whatever the handshakes would have done this cycle.
        if (redirect_valid) begin
            state_nxt = REQ;
        end
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            inst_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            pc         <= redirect_aligned;
            inst_valid <= 1'b0;
        end else begin
            if (fetch_take) begin
                inst_out   <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end
            if (dec_take) begin
                pc         <= pc_inc;
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (dec_take),
        .stall_en  (stall_cycle),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`else
    logic unused_stall_cycle;
    assign unused_stall_cycle = stall_cycle;
    assign perf_fetch_cnt     = '0;
    assign perf_stall_cnt     = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus a randomised handshake phase,
// with fetch addresses and decoded instructions checked through expected queues.
module tb_fetch_seq;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          RAND_N = 24;
    localparam int          BUDGET = 2000;
`ifdef FETCH_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              dec_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;

    fetch_seq #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] dec_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] fetch_m = 0;
    logic [31:0] stall_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor samples mid-cycle; model counters reflect what the DUT shows after the next edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            dec_q.delete();
            fetch_m = 0;
            stall_m = 0;
        end else begin
            if (imem_req && !imem_ready) stall_m++;
            if (redirect_valid) begin
                dec_q.delete();
            end else begin
                if (inst_valid && dec_ready) begin
                    check("dec_q_nonempty", 32'(dec_q.size() != 0), 32'd1);
                    if (dec_q.size() != 0) begin
                        e = dec_q.pop_front();
                        check("inst_pc", inst_pc, e);
                        check("inst_out", inst_out, mem_word(e));
                    end
                    fetch_m++;
                end
                if (imem_req && imem_ready) begin
                    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("fetch_addr", imem_addr, e);
                        dec_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, imem_addr, RST_PC);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst_out, NOP);
        check({tag, "_pc"}, inst_pc, RST_PC);
        check({tag, "_perf_f"}, perf_fetch_cnt, 32'd0);
        check({tag, "_perf_s"}, perf_stall_cnt, 32'd0);
    endtask

    initial begin
        logic [31:0] stall_base;
        logic [31:0] fetch_base;
        int cyc;

        rst = 1'b1; imem_ready = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        check_reset_state("rst");

        // 1: streaming from reset, one instruction every other cycle
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        rst = 1'b0;
        check("s1_req_idle", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s1_req_pattern", 32'(imem_req), 32'((i % 2) == 0));
        end
        check("s1_addr_108", imem_addr, 32'h108);
        dec_ready = 1'b0;
        tick();

        // 3: decode stalls for 5 cycles in HOLD
        for (int i = 0; i < 6; i++) begin
            check("s3_valid", 32'(inst_valid), 32'd1);
            check("s3_pc", inst_pc, 32'h108);
            check("s3_inst", inst_out, mem_word(32'h108));
            check("s3_req", 32'(imem_req), 32'd0);
            if (i == 5) dec_ready = 1'b1;
            tick();
        end
        check("s3_next_addr", imem_addr, 32'h10C);
        check("s3_next_req", 32'(imem_req), 32'd1);

        // 4: redirect together with imem_ready discards the word; then back-to-back redirects
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        check("s4_valid", 32'(inst_valid), 32'd0);
        check("s4_pc_kept", inst_pc, 32'h108);
        check("s4_addr", imem_addr, 32'h200);
        imem_ready = 1'b0; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("s4_last_wins", imem_addr, 32'h0);

        // 2: memory stall of 3 cycles at PC 0
        stall_base = stall_m;
        check("s2_stall_pre", perf_stall_cnt, PERF ? stall_m : 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                exp_q.push_back(32'h0);
                imem_ready = 1'b1;
            end
            check("s2_req", 32'(imem_req), 32'd1);
            check("s2_addr", imem_addr, 32'h0);
            tick();
        end
        check("s2_stall_cnt", perf_stall_cnt, PERF ? stall_base + 32'd3 : 32'd0);
        check("s2_hold_pc", inst_pc, 32'h0);

        // 5: redirect and dec_ready together in HOLD
        fetch_base = fetch_m;
        imem_ready = 1'b0; dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        check("s5_addr", imem_addr, 32'h300);
        check("s5_valid", 32'(inst_valid), 32'd0);
        check("s5_fetch_cnt", perf_fetch_cnt, PERF ? fetch_base : 32'd0);

        // 6: wrap at the top of the address space, then reset mid-REQ
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("s6_addr_top", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        check("s6_hold_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("s6_wrap_addr", imem_addr, 32'h0);
        check("s6_wrap_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b0;
        tick();
        check("s6_fetch_cnt", perf_fetch_cnt, PERF ? fetch_m : 32'd0);
        check("s6_stall_cnt", perf_stall_cnt, PERF ? stall_m : 32'd0);
        rst = 1'b1;
        tick();
        check_reset_state("s6_rst");

        // random handshake phase from reset
        for (int i = 0; i < RAND_N; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        rst = 1'b0;
        cyc = 0;
        while ((exp_q.size() != 0 || dec_q.size() != 0) && cyc < BUDGET) begin
            imem_ready = (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            dec_ready  = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("rand_budget", 32'(cyc < BUDGET), 32'd1);
        imem_ready = 1'b0; dec_ready = 1'b0;
        tick(); tick();
        check("rand_next_addr", imem_addr, RST_PC + 32'(4 * RAND_N));
        check("rand_fetch_cnt", perf_fetch_cnt, PERF ? fetch_m : 32'd0);
        check("rand_fetch_model", fetch_m, 32'(RAND_N));
        check("rand_stall_cnt", perf_stall_cnt, PERF ? stall_m : 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("dec_q_drained", 32'(dec_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
